// File: rtl/prewish_mentor.sv
// Wishbone-style mask initiator: sends one table mask per newmask period over STB/DAT.
// Optional build macro PREWISH_MENTOR_ACK_EN adds ACK_I handshake, ack timeout and retry.
module prewish_mentor #(
  parameter int         NEWMASK_CLK_BITS = 26,
  parameter int         ACK_TIMEOUT_BITS = 4,
  parameter logic [7:0] MASK0            = 8'b10101000,
  parameter logic [7:0] MASK1            = 8'b11001010,
  parameter logic [7:0] MASK2            = 8'b11110000,
  parameter logic [7:0] MASK3            = 8'b10000000
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       ACK_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [1:0] o_index,
  output logic       o_timeout
);

  typedef enum logic [1:0] {START, SEND, IDLE} state_t;

  localparam logic [NEWMASK_CLK_BITS-1:0] DIV_MAX = '1;

  state_t                      state, next_state;
  logic                        launched;
  logic [NEWMASK_CLK_BITS-1:0] div_q, div_d;
  logic                        ack_done, timed_out, send_exit;
  logic                        stb_d, timeout_d;
  logic [7:0]                  dat_d, mask_sel;
  logic [1:0]                  index_d;

`ifdef PREWISH_MENTOR_ACK_EN
  localparam logic [ACK_TIMEOUT_BITS-1:0] TO_MAX = '1;

  logic [ACK_TIMEOUT_BITS-1:0] tcnt_q, tcnt_d;
  logic                        timeout_q;

  // ACK beats the timeout when both land on the same edge.
  always_comb begin
    ack_done  = ACK_I;
    timed_out = !ACK_I && (tcnt_q == TO_MAX);
    tcnt_d    = '0;
    if (state == SEND && !ack_done && !timed_out)
      tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic                        unused_ack;
  logic [ACK_TIMEOUT_BITS-1:0] unused_tcnt;

  assign unused_ack  = ACK_I;
  assign unused_tcnt = '0;
  assign ack_done    = 1'b1;
  assign timed_out   = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign send_exit = ack_done || timed_out;

  // launched delays the first SEND by one START cycle after reset is released.
  always_ff @(posedge CLK_I) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST_I) begin
      state    <= START;
      launched <= 1'b0;
      div_q    <= '0;
      STB_O    <= 1'b0;
      DAT_O    <= 8'h00;
      o_index  <= 2'd0;
    end else begin
      state    <= next_state;
      launched <= 1'b1;
      div_q    <= div_d;
      STB_O    <= stb_d;
      DAT_O    <= dat_d;
      o_index  <= index_d;
    end
  end

  always_comb begin
    // NOTE: a default before any branch keeps this block free of inferred latches.
    next_state = state;
    unique case (state)
      START:   if (launched)          next_state = SEND;
      SEND:    if (send_exit)         next_state = IDLE;
      IDLE:    if (div_q == DIV_MAX)  next_state = SEND;
      default:                        next_state = START;
    endcase
  end

  always_comb begin
    mask_sel = MASK0;
    case (o_index)
      2'd1:    mask_sel = MASK1;
      2'd2:    mask_sel = MASK2;
      2'd3:    mask_sel = MASK3;
      default: mask_sel = MASK0;
    endcase
  end

  // Next values of the registered outputs; DAT_O only reloads on entry to SEND.
  always_comb begin
    stb_d     = (next_state == SEND);
    dat_d     = DAT_O;
    index_d   = o_index;
    div_d     = '0;
    timeout_d = (state == SEND) && timed_out;
    if (next_state == SEND && state != SEND)
      dat_d = mask_sel;
    if (state == SEND && ack_done)
      index_d = o_index + 2'd1;
    if (state == IDLE && next_state == IDLE)
      div_d = div_q + 1'b1;
  end

endmodule

// File: tb/tb_prewish_mentor.sv
// Self-checking bench for prewish_mentor with a short divider; randomized ACK_I
// against a transfer-level model of mask order, strobe length and spacing.
module tb_prewish_mentor;

  localparam int NB      = 4;
  localparam int TO_BITS = 4;
  localparam int PERIOD  = 2**NB + 1;
  localparam int TO_LEN  = 2**TO_BITS;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       ACK_I = 1'b0;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic [1:0] o_index;
  logic       o_timeout;

  logic [7:0] mask_tab [4] = '{8'b10101000, 8'b11001010, 8'b11110000, 8'b10000000};

  int checks = 0;
  int passed = 0;
  int exp_idx = 0;

  prewish_mentor #(
    .NEWMASK_CLK_BITS(NB),
    .ACK_TIMEOUT_BITS(TO_BITS)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .ACK_I    (ACK_I),
    .STB_O    (STB_O),
    .DAT_O    (DAT_O),
    .o_index  (o_index),
    .o_timeout(o_timeout)
  );

  always #5 CLK_I = ~CLK_I;

  // Waits (bounded) for a strobe, then follows it to its falling edge.
  // ack_cycle: strobe cycle in which ACK_I is raised (0 = never); rand_ack drives noise instead.
  task automatic measure_transfer(input int ack_cycle, input bit rand_ack,
                                  output int wait_cnt, output int len,
                                  output logic [7:0] data, output bit stable,
                                  output logic to_pulse, output logic [1:0] idx_after);
    wait_cnt = 0;
    len      = 0;
    data     = 8'hxx;
    stable   = 1'b1;
    while (STB_O !== 1'b1 && wait_cnt < 200) begin
      ACK_I = 1'($urandom_range(0, 1));
      @(negedge CLK_I);
      wait_cnt++;
    end
    if (STB_O === 1'b1) begin
      data  = DAT_O;
      len   = 1;
      ACK_I = rand_ack ? 1'($urandom_range(0, 1)) : (ack_cycle == len);
      while (len < 100) begin
        @(negedge CLK_I);
        if (STB_O !== 1'b1) break;
        len++;
        if (DAT_O !== data) stable = 1'b0;
        ACK_I = rand_ack ? 1'($urandom_range(0, 1)) : (ack_cycle == len);
      end
    end
    to_pulse  = o_timeout;
    idx_after = o_index;
    ACK_I     = 1'b0;
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ACK_I = 1'($urandom_range(0, 1));
      @(negedge CLK_I);
      checks++;
      if (STB_O !== 1'b0 || DAT_O !== 8'h00 || o_index !== 2'd0 || o_timeout !== 1'b0)
        $display("FAIL reset_state: stb=%b dat=%h idx=%0d to=%b, expected 0/00/0/0",
                 STB_O, DAT_O, o_index, o_timeout);
      else passed++;
    end
    ACK_I = 1'b0;
    RST_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b0) $display("FAIL start_cycle: stb=%b expected 0", STB_O);
    else passed++;
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b1 || DAT_O !== mask_tab[0])
      $display("FAIL first_send: stb=%b dat=%b expected 1/%b", STB_O, DAT_O, mask_tab[0]);
    else passed++;
    exp_idx = 0;
  endtask

  task automatic test_reset_mid_send();
    int n;
    n = 0;
    while (STB_O !== 1'b1 && n < 200) begin
      @(negedge CLK_I);
      n++;
    end
    checks++;
    if (STB_O !== 1'b1) $display("FAIL mid_send_wait: no strobe within %0d cycles", n);
    else passed++;
    RST_I = 1'b1;
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b0 || DAT_O !== 8'h00 || o_index !== 2'd0 || o_timeout !== 1'b0)
      $display("FAIL mid_send_reset: stb=%b dat=%h idx=%0d to=%b, expected 0/00/0/0",
               STB_O, DAT_O, o_index, o_timeout);
    else passed++;
    RST_I = 1'b0;
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b0) $display("FAIL mid_send_start: stb=%b expected 0", STB_O);
    else passed++;
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b1 || DAT_O !== mask_tab[0] || o_index !== 2'd0)
      $display("FAIL mid_send_restart: stb=%b dat=%b idx=%0d expected 1/%b/0",
               STB_O, DAT_O, o_index, mask_tab[0]);
    else passed++;
    exp_idx = 0;
  endtask

`ifndef PREWISH_MENTOR_ACK_EN
  // Strobe-only build: random ACK_I must have no effect anywhere.
  task automatic test_strobe_sequence();
    int w, len, prev_len;
    logic [7:0] data;
    bit stable;
    logic to_pulse;
    logic [1:0] idx_after;
    prev_len = 0;
    for (int t = 0; t < 6; t++) begin
      measure_transfer(0, 1'b1, w, len, data, stable, to_pulse, idx_after);
      checks++;
      if (len !== 1 || data !== mask_tab[exp_idx] || to_pulse !== 1'b0)
        $display("FAIL strobe_%0d: len=%0d dat=%b to=%b expected 1/%b/0",
                 t, len, data, to_pulse, mask_tab[exp_idx]);
      else passed++;
      exp_idx = (exp_idx + 1) % 4;
      checks++;
      if (idx_after !== 2'(exp_idx))
        $display("FAIL index_%0d: idx=%0d expected %0d", t, idx_after, exp_idx);
      else passed++;
      if (t > 0) begin
        checks++;
        if (prev_len + w !== PERIOD)
          $display("FAIL spacing_%0d: rise-to-rise=%0d expected %0d", t, prev_len + w, PERIOD);
        else passed++;
      end
      prev_len = len;
    end
  endtask
`else
  // One transfer with ACK in strobe cycle k (0 = never); model predicts the outcome.
  task automatic ack_transfer(input string name, input int k);
    int w, len, exp_len;
    logic [7:0] data;
    bit stable, acked;
    logic to_pulse;
    logic [1:0] idx_after;
    acked   = (k >= 1 && k <= TO_LEN);
    exp_len = acked ? k : TO_LEN;
    measure_transfer(k, 1'b0, w, len, data, stable, to_pulse, idx_after);
    checks++;
    if (len !== exp_len || data !== mask_tab[exp_idx] || !stable)
      $display("FAIL %s_strobe: len=%0d dat=%b stable=%0d expected %0d/%b/1",
               name, len, data, stable, exp_len, mask_tab[exp_idx]);
    else passed++;
    if (acked) exp_idx = (exp_idx + 1) % 4;
    checks++;
    if (idx_after !== 2'(exp_idx) || to_pulse !== !acked)
      $display("FAIL %s_outcome: idx=%0d to=%b expected %0d/%b",
               name, idx_after, to_pulse, exp_idx, !acked);
    else passed++;
    @(negedge CLK_I);
    checks++;
    if (o_timeout !== 1'b0 || STB_O !== 1'b0)
      $display("FAIL %s_after: to=%b stb=%b expected 0/0", name, o_timeout, STB_O);
    else passed++;
  endtask

  task automatic test_ack_held();
    for (int t = 0; t < 5; t++) ack_transfer("ack_held", 1);
  endtask

  task automatic test_timeout_retry();
    ack_transfer("timeout", 0);
    ack_transfer("retry", 1);
  endtask

  task automatic test_ack_coincident();
    ack_transfer("ack_third", 3);
    ack_transfer("ack_at_limit", TO_LEN);
  endtask

  task automatic test_ack_random();
    for (int t = 0; t < 8; t++) ack_transfer("ack_rand", int'($urandom_range(1, TO_LEN + 4)));
  endtask
`endif

  initial begin
    test_reset();
`ifndef PREWISH_MENTOR_ACK_EN
    test_strobe_sequence();
`else
    test_ack_held();
    test_timeout_retry();
    test_ack_coincident();
    test_ack_random();
`endif
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
